// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width and limits, plus the echo stage FSM encoding.
// Used by the mixer, the echo delay and the other downstream stages.
package audio_pkg;

    localparam int SAMPLE_W   = 18;
    localparam int SAMPLE_MAX = 131071;
    localparam int SAMPLE_MIN = -131072;

    typedef enum logic [2:0] {
        ECHO_CLEAR,
        ECHO_IDLE,
        ECHO_READ,
        ECHO_WAIT,
        ECHO_CALC,
        ECHO_WRITE
    } echo_state_t;

endpackage

// File: rtl/echo_delay_ram.sv
// Simple dual-port delay-line memory: synchronous write, registered read with one cycle of latency.
module echo_delay_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 18
) (
    input  logic              i_clock,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/echo_delay.sv
// Feedback echo stage: y = x + floor(y[n-delay] * decay / 8), held in a circular BRAM delay line.
// Define ECHO_SATURATE_EN to clamp y to the sample range; otherwise y wraps in two's complement.
module echo_delay
    import audio_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ready,
    input  logic [SAMPLE_W-1:0] audio_in,
    input  logic                enable,
    input  logic [ADDR_W-1:0]   delay_sel,
    input  logic [2:0]          decay,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int PROD_W = SAMPLE_W + 4;
    localparam int SUM_W  = SAMPLE_W + 1;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(SAMPLE_MAX);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(SAMPLE_MIN);

    echo_state_t r_state, w_next;

    logic [ADDR_W-1:0]          r_wr_ptr;
    logic [ADDR_W-1:0]          r_delay;
    logic [2:0]                 r_decay;
    logic                       r_enable;
    logic signed [SAMPLE_W-1:0] r_x;
    logic signed [SAMPLE_W-1:0] r_audio_out;
    logic                       r_out_valid;
    logic                       r_overrun;

    logic                       w_ram_we;
    logic [SAMPLE_W-1:0]        w_ram_wdata;
    logic                       w_ram_re;
    logic [ADDR_W-1:0]          w_rd_addr;
    logic [SAMPLE_W-1:0]        w_rd_data;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [SUM_W-1:0]    w_echo;
    logic signed [SUM_W-1:0]    w_sum;
    logic signed [SAMPLE_W-1:0] w_y;
    logic                       w_bypass;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ECHO_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ECHO_CLEAR: if (r_wr_ptr == '1) w_next = ECHO_IDLE;
            ECHO_IDLE:  if (ready) w_next = ECHO_READ;
            ECHO_READ:  w_next = ECHO_WAIT;
            ECHO_WAIT:  w_next = ECHO_CALC;
            ECHO_CALC:  w_next = ECHO_WRITE;
            ECHO_WRITE: w_next = ECHO_IDLE;
            default:    w_next = ECHO_CLEAR;
        endcase
    end

    // wr_ptr doubles as the clear address; it wraps back to 0 as CLEAR finishes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_delay     <= '0;
            r_decay     <= '0;
            r_enable    <= 1'b0;
            r_x         <= '0;
            r_audio_out <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= (r_state == ECHO_CALC);
            case (r_state)
                ECHO_CLEAR: r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                ECHO_IDLE: begin
                    if (ready) begin
                        r_x      <= audio_in;
                        r_delay  <= delay_sel;
                        r_decay  <= decay;
                        r_enable <= enable;
                    end
                end
                ECHO_CALC:  r_audio_out <= w_y;
                ECHO_WRITE: r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                default: ;
            endcase
            if (ready && r_state != ECHO_IDLE && r_state != ECHO_CLEAR) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign w_ram_we    = (r_state == ECHO_CLEAR) || (r_state == ECHO_WRITE);
    assign w_ram_wdata = (r_state == ECHO_WRITE) ? r_audio_out : '0;
    assign w_ram_re    = (r_state == ECHO_READ);
    assign w_rd_addr   = r_wr_ptr - r_delay;

    echo_delay_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .i_clock   (clock),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_ram_wdata),
        .i_rd_en   (w_ram_re),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign w_prod   = PROD_W'($signed(w_rd_data)) * PROD_W'($signed({1'b0, r_decay}));
    assign w_echo   = SUM_W'(w_prod >>> 3);
    assign w_sum    = SUM_W'(r_x) + w_echo;
    assign w_bypass = !r_enable || (r_delay == '0);

    always_comb begin
        w_y = r_x;
        if (!w_bypass) begin
`ifdef ECHO_SATURATE_EN
            if (w_sum > SUM_MAX) begin
                w_y = SAMPLE_W'(SUM_MAX);
            end else if (w_sum < SUM_MIN) begin
                w_y = SAMPLE_W'(SUM_MIN);
            end else begin
                w_y = SAMPLE_W'(w_sum);
            end
`else
            w_y = SAMPLE_W'(w_sum);
`endif
        end
    end

    assign audio_out = r_audio_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != ECHO_IDLE);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_echo_delay.sv
// Scoreboard bench for echo_delay: a sample-history model predicts every output value and its cycle.
module tb_echo_delay;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;
    localparam int SMAX   = 131071;
    localparam int SMIN   = -131072;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        ready     = 1'b0;
    logic [17:0] audio_in  = '0;
    logic        enable    = 1'b0;
    logic [11:0] delay_sel = '0;
    logic [2:0]  decay     = '0;
    logic [17:0] audio_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    echo_delay #(.ADDR_W(ADDR_W), .SAMPLE_W(18)) dut (
        .clock     (clock),
        .reset     (reset),
        .ready     (ready),
        .audio_in  (audio_in),
        .enable    (enable),
        .delay_sel (delay_sel),
        .decay     (decay),
        .audio_out (audio_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   hist[DEPTH];
    int   wp;
    int   free_c;
    int   clr_end;
    bit   exp_ovr;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic int floor_div8(input int p);
        int q;
        q = p / 8;
        if ((p % 8) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    function automatic int fit18(input int s);
        int m;
`ifdef ECHO_SATURATE_EN
        if (s > SMAX) return SMAX;
        if (s < SMIN) return SMIN;
        return s;
`else
        m = (s - SMIN) % 262144;
        if (m < 0) m = m + 262144;
        return m + SMIN;
`endif
    endfunction

    task automatic model_reset(input int rel_cyc);
        foreach (hist[i]) hist[i] = 0;
        wp      = 0;
        free_c  = rel_cyc + DEPTH;
        clr_end = rel_cyc + DEPTH;
        exp_ovr = 1'b0;
        sbq.delete();
    endtask

    task automatic model_ready(input int x, input bit en, input int dl, input int dc);
        int d, y;
        if (cyc >= free_c) begin
            if (en && dl != 0) begin
                d = hist[((wp - dl) % DEPTH + DEPTH) % DEPTH];
                y = fit18(x + floor_div8(d * dc));
            end else begin
                y = x;
            end
            hist[wp] = y;
            wp       = (wp + 1) % DEPTH;
            sbq.push_back('{val: y, cyc: cyc + 4});
            free_c   = cyc + 5;
        end else if (cyc >= clr_end) begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic pulse(input int x, input bit en, input int dl, input int dc);
        @(posedge clock); #1;
        audio_in  = 18'(x);
        enable    = en;
        delay_sel = 12'(dl);
        decay     = 3'(dc);
        ready     = 1'b1;
        model_ready(x, en, dl, dc);
        @(posedge clock); #1;
        ready = 1'b0;
    endtask

    task automatic send(input int x, input bit en, input int dl, input int dc);
        while (cyc + 1 < free_c) begin
            @(posedge clock); #1;
        end
        pulse(x, en, dl, dc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy === 1'b1 && n < 5000);
        chk("clear_done_cycle", cyc, clr_end);
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(262143, 0)) + SMIN;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid actual=%0d required=none (cycle %0d)",
                             $signed(audio_out), cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("audio_out", $signed(audio_out), e.val);
                    chk("out_latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish (cycle %0d)", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int c;
        reset = 1'b1;
        model_reset(0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_audio_out", int'(audio_out), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 1);
        chk("reset_overrun", int'(overrun), 0);

        @(posedge clock); #1;
        reset = 1'b0;
        model_reset(cyc);
        pulse(1234, 1'b1, 1, 1);
        wait_idle();
        chk("overrun_after_clear_ready", int'(overrun), 0);

        // impulse through a 4-sample delay at half gain
        send(65536, 1'b1, 4, 4);
        repeat (8) send(0, 1'b1, 4, 4);

        // saturation / wrap with near-unity feedback
        repeat (4) send(SMAX, 1'b1, 1, 7);

        // bypass paths, then echo of the bypassed sample
        send(-5000, 1'b1, 0, 3);
        send(-5000, 1'b0, 5, 3);
        repeat (3) send(0, 1'b1, 1, 4);
        chk("overrun_before_test", int'(overrun), int'(exp_ovr));

        // overrun: second ready two cycles after the first
        send(100, 1'b1, 2, 2);
        pulse(200, 1'b1, 2, 2);
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("overrun_set", int'(overrun), 1);
        send(300, 1'b1, 2, 2);
        send(-300, 1'b1, 2, 2);
        repeat (6) @(negedge clock);
        chk("overrun_sticky", int'(overrun), int'(exp_ovr));

        // reset while the sample sits in CALC
        send(7000, 1'b1, 3, 5);
        c = cyc - 1;
        while (cyc < c + 3) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset(cyc);
        @(negedge clock);
        chk("midop_audio_out", int'(audio_out), 0);
        chk("midop_out_valid", int'(out_valid), 0);
        chk("midop_busy", int'(busy), 1);
        chk("midop_overrun", int'(overrun), 0);
        wait_idle();
        send(1000, 1'b1, 1, 4);
        send(0, 1'b1, 1, 4);

        // pointer wrap: more than DEPTH samples at a fixed delay of 8
        for (int i = 0; i < 4100; i++) begin
            send(rand_sample(), 1'b1, 8, int'($urandom_range(7, 0)));
            repeat ($urandom_range(2, 0)) @(posedge clock);
        end

        // mixed random parameters with occasional early ready pulses
        for (int i = 0; i < 400; i++) begin
            send(rand_sample(), ($urandom_range(3, 0) != 0),
                 ($urandom_range(1, 0) != 0) ? int'($urandom_range(16, 0)) : int'($urandom_range(4095, 0)),
                 int'($urandom_range(7, 0)));
            if ($urandom_range(9, 0) == 0) pulse(rand_sample(), 1'b1, 3, 3);
        end

        repeat (10) @(negedge clock);
        chk("overrun_final", int'(overrun), int'(exp_ovr));
        chk("pending_outputs", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
